// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared opcodes and operand helpers for the pipelined adder/subtractor
package pipe_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Subtraction runs as a + ~b + ~cin, so the borrow-in is inverted on entry.
  function automatic logic eff_cin(input logic op, input logic cin);
    return (op == OP_SUB) ? ~cin : cin;
  endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// rtl/pipe_adder_if.sv - operand/result handshake bundle for pipe_adder
interface pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipe_adder_chunk_adder.sv
// rtl/pipe_adder_chunk_adder.sv - combinational CW-bit full adder with carry in/out
module chunk_adder #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout
);
  logic [CW:0] full;

  assign full        = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
  assign {cout, sum} = full;
endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined add/sub, one CW-bit chunk per stage, valid/ready stall chain
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic         clk,
  input logic         rst,
  pipe_adder_if.slave bus
);
  localparam int CW = WIDTH / STAGES;

  // b is stored already inverted for SUB, so every stage is a plain add.
  typedef struct packed {
    logic             valid;
    logic             op;
    logic             carry;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] psum;
    logic             cout;
    logic             ovf;
  } stage_t;

  stage_t              st  [STAGES];
  stage_t              nxt [STAGES];
  stage_t              in_rec;
  logic [STAGES-1:0]   rdy;

  always_comb begin
    in_rec       = '0;
    in_rec.valid = bus.in_valid;
    in_rec.op    = bus.op;
    in_rec.carry = eff_cin(bus.op, bus.cin);
    in_rec.a     = bus.a;
    in_rec.b     = (bus.op == OP_SUB) ? ~bus.b : bus.b;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t        up;
    stage_t        n;
    logic [CW-1:0] csum;
    logic          cc;

    if (k == 0) begin : g_first
      assign up = in_rec;
    end else begin : g_next
      assign up = st[k-1];
    end

    chunk_adder #(.CW(CW)) u_add (
      .a    (up.a[k*CW +: CW]),
      .b    (up.b[k*CW +: CW]),
      .cin  (up.carry),
      .sum  (csum),
      .cout (cc)
    );

    always_comb begin
      n                   = up;
      n.psum[k*CW +: CW]  = csum;
      n.carry             = cc;
      if (k == STAGES - 1) begin
        n.cout = (up.op == OP_SUB) ? ~cc : cc;
        n.ovf  = (up.a[WIDTH-1] == up.b[WIDTH-1]) && (csum[CW-1] != up.a[WIDTH-1]);
      end
    end

    assign nxt[k] = n;
  end

  // Stage k may load when it is empty or its current beat moves on downstream.
  always_comb begin : stall_chain
    logic down;
    rdy  = '0;
    down = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !st[k].valid || down;
      down   = rdy[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        st[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          if (nxt[k].valid) begin
            st[k] <= nxt[k];
          end else begin
            st[k].valid <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = st[STAGES-1].valid;
  assign bus.sum       = st[STAGES-1].psum;
  assign bus.cout      = st[STAGES-1].cout;
  assign bus.ovf       = st[STAGES-1].ovf;
endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - self-checking bench for pipe_adder at STAGES 4, 1 and 16
module tb_pipe_adder;
  import pipe_adder_pkg::*;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   stg [3] = '{4, 1, 16};

  logic        iv [3];
  logic        ordy [3];
  logic        cn [3];
  logic        opv [3];
  logic [15:0] av [3];
  logic [15:0] bv [3];
  logic        irdy [3];
  logic        ov [3];
  logic        co [3];
  logic        of [3];
  logic [15:0] sm [3];
  logic [17:0] q [3][$];

  pipe_adder_if #(.WIDTH(16)) bus4 ();
  pipe_adder_if #(.WIDTH(16)) bus1 ();
  pipe_adder_if #(.WIDTH(16)) bus16 ();

  pipe_adder #(.WIDTH(16), .STAGES(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
  pipe_adder #(.WIDTH(16), .STAGES(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
  pipe_adder #(.WIDTH(16), .STAGES(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  assign bus4.in_valid  = iv[0];
  assign bus4.a         = av[0];
  assign bus4.b         = bv[0];
  assign bus4.cin       = cn[0];
  assign bus4.op        = opv[0];
  assign bus4.out_ready = ordy[0];
  assign irdy[0]        = bus4.in_ready;
  assign ov[0]          = bus4.out_valid;
  assign sm[0]          = bus4.sum;
  assign co[0]          = bus4.cout;
  assign of[0]          = bus4.ovf;

  assign bus1.in_valid  = iv[1];
  assign bus1.a         = av[1];
  assign bus1.b         = bv[1];
  assign bus1.cin       = cn[1];
  assign bus1.op        = opv[1];
  assign bus1.out_ready = ordy[1];
  assign irdy[1]        = bus1.in_ready;
  assign ov[1]          = bus1.out_valid;
  assign sm[1]          = bus1.sum;
  assign co[1]          = bus1.cout;
  assign of[1]          = bus1.ovf;

  assign bus16.in_valid  = iv[2];
  assign bus16.a         = av[2];
  assign bus16.b         = bv[2];
  assign bus16.cin       = cn[2];
  assign bus16.op        = opv[2];
  assign bus16.out_ready = ordy[2];
  assign irdy[2]         = bus16.in_ready;
  assign ov[2]           = bus16.out_valid;
  assign sm[2]           = bus16.sum;
  assign co[2]           = bus16.cout;
  assign of[2]           = bus16.ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; returns {sum, cout/borrow, signed overflow}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic op);
    int ua, ub, sa, sb, ci, r, sr;
    logic c;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ci = cin ? 1 : 0;
    if (op == OP_ADD) begin
      r  = ua + ub + ci;
      sr = sa + sb + ci;
      c  = (r > 65535);
    end else begin
      r  = ua - ub - ci;
      sr = sa - sb - ci;
      c  = (r < 0);
    end
    return {r[15:0], c, (sr > 32767) || (sr < -32768)};
  endfunction

  function automatic logic [17:0] res(input int i);
    return {sm[i], co[i], of[i]};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 4))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Presents one beat from mid-cycle and measures cycles until out_valid.
  task automatic send_one(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic op, input logic [17:0] exp);
    int c0;
    int lat;
    iv[i] = 1'b1; av[i] = a; bv[i] = b; cn[i] = cin; opv[i] = op; ordy[i] = 1'b1;
    #1;
    check($sformatf("accept_s%0d", stg[i]), 32'(irdy[i]), 1);
    c0 = cyc;
    @(posedge clk); #1;
    iv[i] = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ov[i]) begin
        lat = cyc - c0;
        break;
      end
    end
    check($sformatf("latency_s%0d", stg[i]), lat, stg[i]);
    check($sformatf("result_s%0d_%h_%h", stg[i], a, b), 32'(res(i)), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic observe();
    for (int i = 0; i < 3; i++) begin
      if (ov[i] && ordy[i]) begin
        if (q[i].size() == 0) check($sformatf("rand_spurious_s%0d", stg[i]), 32'(ov[i]), 0);
        else check($sformatf("rand_s%0d", stg[i]), 32'(res(i)), 32'(q[i].pop_front()));
      end
      if (iv[i] && irdy[i]) q[i].push_back(model(av[i], bv[i], cn[i], opv[i]));
    end
  endtask

  task automatic backpressure();
    int nin = 0;
    int nout = 0;
    int inflight;
    logic [17:0] held = '0;
    bit have_held = 0;
    bit saw_full = 0;
    bit saw_pp = 0;
    for (int t = 0; t < 60 && nout < 10; t++) begin
      iv[0] = (nin < 10); av[0] = nin[15:0]; bv[0] = 16'h0100; cn[0] = 1'b0; opv[0] = OP_ADD;
      ordy[0] = !(t >= 3 && t <= 8);
      @(negedge clk);
      inflight = nin - nout;
      if (iv[0] && !irdy[0] && !saw_full) begin
        saw_full = 1;
        check("bp_full_depth", inflight, 4);
      end
      if (ov[0] && ordy[0] && inflight == 4 && !saw_pp) begin
        saw_pp = 1;
        check("bp_pop_push_ready", 32'(irdy[0]), 1);
      end
      if (ov[0] && !ordy[0]) begin
        if (have_held) check("bp_stable", 32'(res(0)), 32'(held));
        held = res(0);
        have_held = 1;
      end else begin
        have_held = 0;
      end
      if (ov[0] && ordy[0]) begin
        check("bp_order", 32'(sm[0]), 32'h0100 + nout);
        nout++;
      end
      if (iv[0] && irdy[0]) nin++;
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    check("bp_count_out", nout, 10);
    check("bp_saw_full", 32'(saw_full), 1);
    check("bp_saw_pop_push", 32'(saw_pp), 1);
  endtask

  task automatic reset_midstream();
    bit seen = 0;
    int stale = 0;
    ordy[0] = 1'b0;
    for (int t = 0; t < 3; t++) begin
      iv[0] = 1'b1; av[0] = 16'(16'h0010 + t); bv[0] = 16'h0001; cn[0] = 1'b0; opv[0] = OP_ADD;
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ov[0]) begin
        seen = 1;
        break;
      end
    end
    check("rst_prefill_valid", 32'(seen), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(ov[0]), 0);
    check("rst_async_ready", 32'(irdy[0]), 1);
    check("rst_async_result", 32'(res(0)), 0);
    #1 rst = 1'b0;
    ordy[0] = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (ov[0]) stale++;
    end
    check("rst_no_stale", stale, 0);
    @(posedge clk); #1;
    send_one(0, 16'h00AA, 16'h0055, 1'b0, OP_ADD, {16'h00FF, 1'b0, 1'b0});
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; cn[i] = 1'b0; opv[i] = OP_ADD; av[i] = '0; bv[i] = '0;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_valid_s%0d", stg[i]), 32'(ov[i]), 0);
      check($sformatf("reset_ready_s%0d", stg[i]), 32'(irdy[i]), 1);
      check($sformatf("reset_result_s%0d", stg[i]), 32'(res(i)), 0);
    end
    #2 rst = 1'b0;

    send_one(0, 16'hFFFF, 16'h0001, 1'b0, OP_ADD, {16'h0000, 1'b1, 1'b0});
    send_one(0, 16'h7FFF, 16'h0001, 1'b0, OP_ADD, {16'h8000, 1'b0, 1'b1});
    send_one(0, 16'h1234, 16'h4321, 1'b1, OP_ADD, {16'h5556, 1'b0, 1'b0});
    send_one(0, 16'h0005, 16'h0007, 1'b0, OP_SUB, {16'hFFFE, 1'b1, 1'b0});
    send_one(0, 16'h8000, 16'h0001, 1'b0, OP_SUB, {16'h7FFF, 1'b0, 1'b1});
    send_one(0, 16'h0000, 16'h0001, 1'b0, OP_SUB, {16'hFFFF, 1'b1, 1'b0});
    send_one(1, 16'hFFFF, 16'h0001, 1'b0, OP_ADD, {16'h0000, 1'b1, 1'b0});
    send_one(2, 16'h0000, 16'h0001, 1'b0, OP_SUB, {16'hFFFF, 1'b1, 1'b0});

    backpressure();
    reset_midstream();

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        ordy[i] = ($urandom_range(0, 3) != 0);
        iv[i]   = ($urandom_range(0, 2) != 0);
        av[i]   = pick();
        bv[i]   = pick();
        cn[i]   = 1'($urandom);
        opv[i]  = 1'($urandom);
      end
      @(negedge clk);
      observe();
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b1;
    end
    for (int k = 0; k < 60; k++) begin
      if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0) break;
      @(negedge clk);
      observe();
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drain_empty_s%0d", stg[i]), q[i].size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
